// File: rtl/mdio_pkg.sv
// -----------------------------------------------------------------------------
// mdio_pkg
// Shared definitions for the Clause-22 MDIO responder.
//   - mdio_state_e : frame decoder states
//   - ST / OP_*    : start-of-frame and opcode encodings
//   - *_W          : field widths
//   - BIT_*        : frame bit positions (bit 1 = first ST bit after preamble)
//   - addr_match() : PHY address / broadcast-write acceptance
// -----------------------------------------------------------------------------
package mdio_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ST2     = 3'd1,
        OP      = 3'd2,
        ADDR    = 3'd3,
        LISTEN  = 3'd4,
        TA      = 3'd5,
        RD_DATA = 3'd6,
        WR_DATA = 3'd7
    } mdio_state_e;

    localparam logic [1:0] ST    = 2'b01;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_RD = 2'b10;

    localparam int PHYAD_W = 5;
    localparam int REGAD_W = 5;
    localparam int DATA_W  = 16;
    localparam int BIT_W   = 6;

    // Bit position of the bit sampled on a given rising edge.
    localparam logic [BIT_W-1:0] BIT_ST2       = 6'd2;
    localparam logic [BIT_W-1:0] BIT_OP_FIRST  = 6'd3;
    localparam logic [BIT_W-1:0] BIT_ADDR_LAST = 6'd14;
    localparam logic [BIT_W-1:0] BIT_TA_FIRST  = 6'd15;
    localparam logic [BIT_W-1:0] BIT_LAST      = 6'd32;

    // A frame is ours if it targets our address, or if it is a write to
    // address 0 and broadcast writes are enabled. Reads on address 0 are
    // never answered.
    function automatic logic addr_match(
        input logic [PHYAD_W-1:0] phyad,
        input logic [PHYAD_W-1:0] own_addr,
        input logic               bcast_en,
        input logic               is_write
    );
        logic hit;
        hit = (phyad == own_addr);
        if (bcast_en && is_write && (phyad == 5'd0)) begin
            hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/mdio_pad.sv
// -----------------------------------------------------------------------------
// mdio_pad
// Open-drain style tristate buffer for the shared MDIO line. Keeps the decoder
// core free of inout handling.
//   mdio_o  : value to drive when enabled
//   mdio_oe : 1 = drive mdio_o, 0 = release (external pullup holds the line)
//   mdio_i  : line value as seen by the core
//   mdio    : shared bidirectional line
// -----------------------------------------------------------------------------
module mdio_pad (
    input  logic mdio_o,
    input  logic mdio_oe,
    output logic mdio_i,
    inout  wire  mdio
);

    assign mdio   = mdio_oe ? mdio_o : 1'bz;
    assign mdio_i = mdio;

endmodule

// File: rtl/mdio_slave.sv
// -----------------------------------------------------------------------------
// mdio_slave
// Clause-22 MDIO management responder (PHY side). Decodes frames on the shared
// mdio line, clocked by mdc, and presents register reads/writes to an external
// 32x16 register bank. Read data is driven back during turnaround/data bits.
//
// Parameters:
//   PHY_ADDR : address answered by this responder
//   PRE_MIN  : preamble 1s required before ST (0 = preamble suppression)
//   BCAST_EN : also accept writes addressed to PHYAD 0
//
// Ports:
//   mdc         : management clock, all logic on rising edge
//   rst         : synchronous active-high reset
//   mdio        : shared open-drain data line
//   reg_addr    : REGAD of the current frame, updated when REGAD completes
//   reg_wr_data : write data, valid while reg_wr_en is high
//   reg_wr_en   : one-cycle write strobe
//   reg_rd_en   : one-cycle read request; bank answers by the next rising edge
//   reg_rd_data : read data from the bank
//   busy        : high from accepted ST until frame end
//   frame_err   : one-cycle pulse on a malformed ST or OP field
// -----------------------------------------------------------------------------
module mdio_slave
    import mdio_pkg::*;
#(
    parameter logic [PHYAD_W-1:0] PHY_ADDR = 5'b00001,
    parameter int                 PRE_MIN  = 32,
    parameter bit                 BCAST_EN = 1'b0
) (
    input  logic                mdc,
    input  logic                rst,
    inout  wire                 mdio,
    output logic [REGAD_W-1:0]  reg_addr,
    output logic [DATA_W-1:0]   reg_wr_data,
    output logic                reg_wr_en,
    output logic                reg_rd_en,
    input  logic [DATA_W-1:0]   reg_rd_data,
    output logic                busy,
    output logic                frame_err
);

    // Preamble counter only needs to reach PRE_MIN, where it saturates.
    localparam int                PRE_W   = (PRE_MIN < 1) ? 1 : $clog2(PRE_MIN + 1);
    localparam logic [PRE_W-1:0]  PRE_SAT = PRE_W'(PRE_MIN);
    localparam logic [PRE_W-1:0]  PRE_ONE = PRE_W'(1);

    mdio_state_e                        state_r;
    logic [BIT_W-1:0]                   bit_r;       // bit sampled on the next edge
    logic [PRE_W-1:0]                   pre_cnt_r;
    logic                               op_hi_r;     // first OP bit
    logic                               op_wr_r;     // 1 = write frame
    logic [PHYAD_W+REGAD_W-2:0]         addr_sr_r;   // PHYAD/REGAD bits so far
    logic [DATA_W-1:0]                  data_sr_r;   // read or write data shifter
    logic                               drv_o_r;
    logic                               drv_oe_r;

    logic                               mdio_in_s;
    logic [PHYAD_W+REGAD_W-1:0]         addr_full_s;
    logic                               match_s;
    logic [BIT_W-1:0]                   bit_next_s;

    // Tristate buffer for the shared line.
    mdio_pad u_pad (
        .mdio_o  (drv_o_r),
        .mdio_oe (drv_oe_r),
        .mdio_i  (mdio_in_s),
        .mdio    (mdio)
    );

    // The full address is only meaningful on the edge that samples bit 14,
    // where the current line value supplies the last REGAD bit.
    assign addr_full_s = {addr_sr_r, mdio_in_s};
    assign match_s     = addr_match(addr_full_s[PHYAD_W+REGAD_W-1:REGAD_W],
                                    PHY_ADDR, BCAST_EN, op_wr_r);
    assign bit_next_s  = bit_r + 6'd1;

    // Frame decoder: preamble hunt, header decode, turnaround and data phases.
    always_ff @(posedge mdc) begin
        if (rst) begin
            state_r     <= IDLE;
            bit_r       <= 6'd0;
            pre_cnt_r   <= '0;
            op_hi_r     <= 1'b0;
            op_wr_r     <= 1'b0;
            addr_sr_r   <= '0;
            data_sr_r   <= 16'h0000;
            drv_o_r     <= 1'b0;
            drv_oe_r    <= 1'b0;
            reg_addr    <= 5'd0;
            reg_wr_data <= 16'h0000;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            busy        <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            frame_err <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (mdio_in_s != ST[1]) begin
                        if (pre_cnt_r != PRE_SAT) begin
                            pre_cnt_r <= pre_cnt_r + PRE_ONE;
                        end else begin
                            pre_cnt_r <= pre_cnt_r;
                        end
                    end else if (pre_cnt_r >= PRE_SAT) begin
                        // First ST bit after a long enough preamble.
                        state_r   <= ST2;
                        bit_r     <= BIT_ST2;
                        pre_cnt_r <= '0;
                    end else begin
                        pre_cnt_r <= '0;
                    end
                end

                ST2: begin
                    if (mdio_in_s == ST[0]) begin
                        state_r <= OP;
                        bit_r   <= BIT_OP_FIRST;
                        busy    <= 1'b1;
                    end else begin
                        state_r   <= IDLE;
                        bit_r     <= 6'd0;
                        frame_err <= 1'b1;
                    end
                end

                OP: begin
                    bit_r <= bit_next_s;
                    if (bit_r == BIT_OP_FIRST) begin
                        op_hi_r <= mdio_in_s;
                    end else begin
                        case ({op_hi_r, mdio_in_s})
                            OP_WR: begin
                                op_wr_r <= 1'b1;
                                state_r <= ADDR;
                            end
                            OP_RD: begin
                                op_wr_r <= 1'b0;
                                state_r <= ADDR;
                            end
                            default: begin
                                state_r   <= IDLE;
                                bit_r     <= 6'd0;
                                busy      <= 1'b0;
                                frame_err <= 1'b1;
                            end
                        endcase
                    end
                end

                ADDR: begin
                    addr_sr_r <= addr_full_s[PHYAD_W+REGAD_W-2:0];
                    bit_r     <= bit_next_s;
                    if (bit_r == BIT_ADDR_LAST) begin
                        reg_addr <= addr_full_s[REGAD_W-1:0];
                        if (match_s) begin
                            state_r <= TA;
                            // Bank sees the request in the cycle after bit 14
                            // and answers before the edge that samples bit 15.
                            reg_rd_en <= ~op_wr_r;
                        end else begin
                            state_r <= LISTEN;
                        end
                    end else begin
                        state_r <= ADDR;
                    end
                end

                LISTEN: begin
                    // Foreign frame: just count bits until it ends.
                    if (bit_r == BIT_LAST) begin
                        state_r <= IDLE;
                        bit_r   <= 6'd0;
                        busy    <= 1'b0;
                    end else begin
                        bit_r <= bit_next_s;
                    end
                end

                TA: begin
                    bit_r <= bit_next_s;
                    if (bit_r == BIT_TA_FIRST) begin
                        if (!op_wr_r) begin
                            // Second TA bit is driven low by the responder.
                            data_sr_r <= reg_rd_data;
                            drv_o_r   <= 1'b0;
                            drv_oe_r  <= 1'b1;
                        end else begin
                            drv_oe_r <= 1'b0;
                        end
                    end else if (!op_wr_r) begin
                        // Line carries bit i+1 from edge i, so D15 goes out now.
                        drv_o_r   <= data_sr_r[DATA_W-1];
                        data_sr_r <= {data_sr_r[DATA_W-2:0], 1'b0};
                        state_r   <= RD_DATA;
                    end else begin
                        state_r <= WR_DATA;
                    end
                end

                RD_DATA: begin
                    if (bit_r == BIT_LAST) begin
                        drv_oe_r <= 1'b0;
                        drv_o_r  <= 1'b0;
                        state_r  <= IDLE;
                        bit_r    <= 6'd0;
                        busy     <= 1'b0;
                    end else begin
                        drv_o_r   <= data_sr_r[DATA_W-1];
                        data_sr_r <= {data_sr_r[DATA_W-2:0], 1'b0};
                        bit_r     <= bit_next_s;
                    end
                end

                WR_DATA: begin
                    data_sr_r <= {data_sr_r[DATA_W-2:0], mdio_in_s};
                    if (bit_r == BIT_LAST) begin
                        reg_wr_data <= {data_sr_r[DATA_W-2:0], mdio_in_s};
                        reg_wr_en   <= 1'b1;
                        state_r     <= IDLE;
                        bit_r       <= 6'd0;
                        busy        <= 1'b0;
                    end else begin
                        bit_r <= bit_next_s;
                    end
                end

                default: begin
                    state_r   <= IDLE;
                    bit_r     <= 6'd0;
                    pre_cnt_r <= '0;
                    drv_oe_r  <= 1'b0;
                    drv_o_r   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdio_slave.sv
// -----------------------------------------------------------------------------
// tb_mdio_slave
// Directed bench for mdio_slave. A simple master drives frames bit by bit on
// the falling edge; the line and DUT outputs are recorded per bit and checked
// against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mdio_slave;

    logic        mdc = 1'b0;
    logic        rst = 1'b0;
    wire         mdio;
    logic        m_oe = 1'b0;
    logic        m_o  = 1'b0;
    logic [15:0] rd_value = 16'h0000;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wr_data;
    logic        reg_wr_en;
    logic        reg_rd_en;
    logic        busy;
    logic        frame_err;

    integer vectors    = 0;
    integer miscompares = 0;

    assign mdio = m_oe ? m_o : 1'bz;
    pullup (mdio);

    always #10 mdc = ~mdc;

    mdio_slave #(
        .PHY_ADDR (5'b00001),
        .PRE_MIN  (32),
        .BCAST_EN (1'b0)
    ) u_dut (
        .mdc         (mdc),
        .rst         (rst),
        .mdio        (mdio),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_rd_data (rd_value),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    // Bit sequence: {drive, value}. Index base = frame bit 1.
    logic [1:0]  seq[$];
    int          base;
    logic        obs_line [256];
    logic        obs_wr   [256];
    logic        obs_rd   [256];
    logic        obs_busy [256];
    logic        obs_err  [256];
    logic        obs_oe   [256];
    logic [4:0]  obs_addr [256];
    logic [15:0] obs_wdata[256];

    task automatic push_bits(input logic [31:0] val, input int n, input logic drv);
        for (int i = n - 1; i >= 0; i--) seq.push_back({drv, val[i]});
    endtask

    task automatic build(input logic clr, input int pre, input logic [1:0] st,
                         input logic [1:0] op, input logic [4:0] phy,
                         input logic [4:0] rg, input logic rd, input logic [15:0] data);
        seq.delete();
        if (clr) push_bits(32'd0, 1, 1'b1);
        push_bits(32'hFFFF_FFFF, pre, 1'b1);
        base = seq.size();
        push_bits({30'd0, st}, 2, 1'b1);
        push_bits({30'd0, op}, 2, 1'b1);
        push_bits({27'd0, phy}, 5, 1'b1);
        push_bits({27'd0, rg}, 5, 1'b1);
        if (rd) begin
            push_bits(32'd0, 18, 1'b0);
        end else begin
            push_bits(32'd2, 2, 1'b1);
            push_bits({16'd0, data}, 16, 1'b1);
        end
        push_bits(32'd0, 2, 1'b0);
    endtask

    task automatic play(input int rst_idx);
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge mdc);
            m_oe = seq[i][1];
            m_o  = seq[i][0];
            rst  = (i == rst_idx);
            #1;
            obs_line[i] = mdio;
            @(posedge mdc);
            #1;
            obs_wr[i]    = reg_wr_en;
            obs_rd[i]    = reg_rd_en;
            obs_busy[i]  = busy;
            obs_err[i]   = frame_err;
            obs_oe[i]    = u_dut.drv_oe_r;
            obs_addr[i]  = reg_addr;
            obs_wdata[i] = reg_wr_data;
        end
        @(negedge mdc);
        m_oe = 1'b0;
        rst  = 1'b0;
    endtask

    task automatic test_reset;
        m_oe = 1'b0;
        rst  = 1'b1;
        repeat (3) @(posedge mdc);
        #1;
        rst = 1'b0;
        vectors++;
        if ({reg_wr_en, reg_rd_en, busy, frame_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_strobes got %b want 0000", {reg_wr_en, reg_rd_en, busy, frame_err});
        end
        vectors++;
        if ({reg_addr, reg_wr_data} !== 21'd0) begin
            miscompares++;
            $display("FAIL reset_regs got addr %h data %h want 0/0", reg_addr, reg_wr_data);
        end
        vectors++;
        if (mdio !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mdio got %b want 1 (released)", mdio);
        end
    endtask

    task automatic test_write;
        int nwr, nrd, noe;
        build(1'b0, 32, 2'b01, 2'b01, 5'd1, 5'd0, 1'b0, 16'h2100);
        play(-1);
        nwr = 0; nrd = 0; noe = 0;
        for (int i = 0; i < seq.size(); i++) begin
            nwr += int'(obs_wr[i]);
            nrd += int'(obs_rd[i]);
            noe += int'(obs_oe[i]);
        end
        vectors++;
        if (obs_wr[base + 31] !== 1'b1 || nwr != 1) begin
            miscompares++;
            $display("FAIL wr_strobe got at_E32=%b count=%0d want 1/1", obs_wr[base + 31], nwr);
        end
        vectors++;
        if (obs_wdata[base + 31] !== 16'h2100 || obs_addr[base + 31] !== 5'd0) begin
            miscompares++;
            $display("FAIL wr_data got %h addr %h want 2100/00", obs_wdata[base + 31], obs_addr[base + 31]);
        end
        vectors++;
        if (noe != 0 || nrd != 0) begin
            miscompares++;
            $display("FAIL wr_no_drive got oe_cycles=%0d rd=%0d want 0/0", noe, nrd);
        end
        vectors++;
        if ({obs_busy[base], obs_busy[base + 1], obs_busy[base + 30], obs_busy[base + 31]} !== 4'b0110) begin
            miscompares++;
            $display("FAIL wr_busy got %b want 0110", {obs_busy[base], obs_busy[base + 1],
                     obs_busy[base + 30], obs_busy[base + 31]});
        end
    endtask

    task automatic test_read;
        int nrd;
        logic [15:0] word;
        rd_value = 16'hBEEF;
        build(1'b0, 32, 2'b01, 2'b10, 5'd1, 5'd5, 1'b1, 16'h0000);
        play(-1);
        nrd = 0;
        for (int i = 0; i < seq.size(); i++) nrd += int'(obs_rd[i]);
        for (int k = 0; k < 16; k++) word[15 - k] = obs_line[base + 16 + k];
        vectors++;
        if (obs_rd[base + 13] !== 1'b1 || nrd != 1) begin
            miscompares++;
            $display("FAIL rd_strobe got after_E14=%b count=%0d want 1/1", obs_rd[base + 13], nrd);
        end
        vectors++;
        if (obs_addr[base + 12] !== 5'd0 || obs_addr[base + 13] !== 5'd5) begin
            miscompares++;
            $display("FAIL rd_addr got E13=%h E14=%h want 00/05", obs_addr[base + 12], obs_addr[base + 13]);
        end
        vectors++;
        if ({obs_line[base + 14], obs_line[base + 15]} !== 2'b10) begin
            miscompares++;
            $display("FAIL rd_turnaround got %b want 10", {obs_line[base + 14], obs_line[base + 15]});
        end
        vectors++;
        if (word !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL rd_data got %h want beef", word);
        end
        vectors++;
        if (obs_line[base + 32] !== 1'b1 || obs_oe[base + 31] !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_release got line=%b oe=%b want 1/0", obs_line[base + 32], obs_oe[base + 31]);
        end
    endtask

    task automatic test_no_match;
        int nrd, nerr, nlow;
        rd_value = 16'h0000;
        build(1'b0, 32, 2'b01, 2'b10, 5'd3, 5'd5, 1'b1, 16'h0000);
        play(-1);
        nrd = 0; nerr = 0; nlow = 0;
        for (int i = 0; i < seq.size(); i++) begin
            nrd  += int'(obs_rd[i]);
            nerr += int'(obs_err[i]);
        end
        for (int i = base + 14; i < seq.size(); i++) nlow += int'(obs_line[i] !== 1'b1);
        vectors++;
        if (nrd != 0 || nerr != 0) begin
            miscompares++;
            $display("FAIL nomatch_strobes got rd=%0d err=%0d want 0/0", nrd, nerr);
        end
        vectors++;
        if (nlow != 0) begin
            miscompares++;
            $display("FAIL nomatch_line got %0d non-released bits want 0", nlow);
        end
    endtask

    task automatic test_short_preamble;
        int nwr, nbusy, nerr;
        build(1'b1, 31, 2'b01, 2'b01, 5'd1, 5'd2, 1'b0, 16'h1234);
        play(-1);
        nwr = 0; nbusy = 0; nerr = 0;
        for (int i = 0; i < seq.size(); i++) begin
            nwr   += int'(obs_wr[i]);
            nbusy += int'(obs_busy[i]);
            nerr  += int'(obs_err[i]);
        end
        vectors++;
        if (nwr != 0 || nbusy != 0 || nerr != 0) begin
            miscompares++;
            $display("FAIL short_pre_ignored got wr=%0d busy=%0d err=%0d want 0/0/0", nwr, nbusy, nerr);
        end
        build(1'b0, 32, 2'b01, 2'b01, 5'd1, 5'd7, 1'b0, 16'hA5C3);
        play(-1);
        vectors++;
        if (obs_wr[base + 31] !== 1'b1 || obs_wdata[base + 31] !== 16'hA5C3 || obs_addr[base + 31] !== 5'd7) begin
            miscompares++;
            $display("FAIL short_pre_next got wr=%b data=%h addr=%h want 1/a5c3/07",
                     obs_wr[base + 31], obs_wdata[base + 31], obs_addr[base + 31]);
        end
    endtask

    task automatic test_bad_frames;
        int nerr, nwr;
        build(1'b0, 32, 2'b01, 2'b11, 5'd1, 5'd0, 1'b1, 16'h0000);
        play(-1);
        nerr = 0; nwr = 0;
        for (int i = 0; i < seq.size(); i++) begin
            nerr += int'(obs_err[i]);
            nwr  += int'(obs_wr[i]) + int'(obs_rd[i]);
        end
        vectors++;
        if (obs_err[base + 3] !== 1'b1 || nerr != 1 || nwr != 0) begin
            miscompares++;
            $display("FAIL bad_op got err_E4=%b errs=%0d strobes=%0d want 1/1/0", obs_err[base + 3], nerr, nwr);
        end
        vectors++;
        if (obs_busy[base + 3] !== 1'b0) begin
            miscompares++;
            $display("FAIL bad_op_busy got %b want 0", obs_busy[base + 3]);
        end
        build(1'b0, 32, 2'b00, 2'b01, 5'd1, 5'd0, 1'b0, 16'h0000);
        play(-1);
        nerr = 0;
        for (int i = 0; i < seq.size(); i++) nerr += int'(obs_err[i]);
        vectors++;
        if (obs_err[base + 1] !== 1'b1 || nerr != 1) begin
            miscompares++;
            $display("FAIL bad_st got err_E2=%b errs=%0d want 1/1", obs_err[base + 1], nerr);
        end
    endtask

    task automatic test_reset_mid_read;
        int nwr;
        rd_value = 16'h0000;
        build(1'b0, 32, 2'b01, 2'b10, 5'd1, 5'd9, 1'b1, 16'h0000);
        play(base + 19);
        nwr = 0;
        for (int i = 0; i < seq.size(); i++) nwr += int'(obs_wr[i]);
        vectors++;
        if ({obs_line[base + 19], obs_line[base + 20]} !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_mid_line got %b want 01", {obs_line[base + 19], obs_line[base + 20]});
        end
        vectors++;
        if (obs_oe[base + 19] !== 1'b0 || obs_busy[base + 19] !== 1'b0 ||
            obs_addr[base + 19] !== 5'd0 || nwr != 0) begin
            miscompares++;
            $display("FAIL rst_mid_state got oe=%b busy=%b addr=%h wr=%0d want 0/0/00/0",
                     obs_oe[base + 19], obs_busy[base + 19], obs_addr[base + 19], nwr);
        end
        build(1'b0, 32, 2'b01, 2'b01, 5'd1, 5'd3, 1'b0, 16'h5A0F);
        play(-1);
        vectors++;
        if (obs_wr[base + 31] !== 1'b1 || obs_wdata[base + 31] !== 16'h5A0F || obs_addr[base + 31] !== 5'd3) begin
            miscompares++;
            $display("FAIL rst_mid_next got wr=%b data=%h addr=%h want 1/5a0f/03",
                     obs_wr[base + 31], obs_wdata[base + 31], obs_addr[base + 31]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_no_match();
        test_short_preamble();
        test_bad_frames();
        test_reset_mid_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
